// File: rtl/edge_event_pkg.sv
// Shared types and helpers for the edge event arbiter: FSM encoding,
// round-robin pick result and the channel-index width helper.
package edge_event_pkg;

   localparam int MAX_CH = 32;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } evt_state_t;

   typedef struct packed {
      logic       found;
      logic [4:0] idx;
   } rr_pick_t;

   function automatic int ch_w(input int n);
      return $clog2(n);
   endfunction

   // First set bit of pend[n-1:0], searching upward from last+1 and wrapping.
   function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] pend,
                                        input int unsigned last,
                                        input int unsigned n);
      rr_pick_t    r;
      int unsigned idx;
      r = '0;
      for (int unsigned i = 1; i <= MAX_CH; i++) begin
         idx = (last + i) % n;
         if (i <= n && !r.found && pend[idx[4:0]]) begin
            r.found = 1'b1;
            r.idx   = idx[4:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/edge_event_arbiter_sync.sv
// Per-channel synchronizer followed by a registered one-cycle rising-edge pulse.
module edge_pulse_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   hist;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
         hist <= 1'b0;
         q    <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d};
         hist <= sync[SYNC_STAGES-1];
         q    <= sync[SYNC_STAGES-1] & ~hist;
      end
   end

endmodule

// File: rtl/edge_event_arbiter.sv
// Latches synchronized rising edges as pending events and offers them one at a
// time, round-robin, on a valid/ready port; counts events lost to overrun.
module edge_event_arbiter
   import edge_event_pkg::*;
#(
   parameter  int N_CH        = 8,
   parameter  int SYNC_STAGES = 2,
   parameter  int CNT_W       = 8,
   localparam int CH_W        = ch_w(N_CH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N_CH-1:0]  d,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [CH_W-1:0]  evt_ch,
   output logic [N_CH-1:0]  pending,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             drop_flag,
   input  logic             clr_drop
);

   localparam int SUM_W = CNT_W + 6;

   logic [N_CH-1:0]   rise;
   evt_state_t        state;
   logic [CH_W-1:0]   last_grant;
   logic              accept;
   logic [N_CH-1:0]   acc_mask, lost, pend_next, cand;
   logic [MAX_CH-1:0] pick_src;
   logic [CH_W-1:0]   pick_last, pick_idx;
   rr_pick_t          pick;
   logic [5:0]        n_lost;
   logic [CNT_W-1:0]  cnt_base, cnt_next;
   logic [SUM_W-1:0]  cnt_sum;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      edge_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk (clk),
         .rst (rst),
         .d   (d[i]),
         .q   (rise[i])
      );
   end

   assign accept = evt_valid & evt_ready;

   always_comb begin
      acc_mask = '0;
      if (accept) acc_mask[evt_ch] = 1'b1;
      lost      = rise & pending & ~acc_mask;
      pend_next = (pending & ~acc_mask) | rise;
      // After a handshake the accepted channel only competes again if it re-rose.
      cand      = accept ? ((pending & ~acc_mask) | (rise & acc_mask)) : pending;
      pick_src  = '0;
      pick_src[N_CH-1:0] = cand;
      pick_last = accept ? evt_ch : last_grant;
      pick      = rr_pick(pick_src, 32'(pick_last), N_CH);
      pick_idx  = CH_W'(pick.idx);
   end

   always_comb begin
      n_lost = '0;
      for (int i = 0; i < N_CH; i++) n_lost = n_lost + 6'(lost[i]);
      cnt_base = clr_drop ? '0 : drop_cnt;
      cnt_sum  = SUM_W'(cnt_base) + SUM_W'(n_lost);
      cnt_next = (|cnt_sum[SUM_W-1:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         evt_valid  <= 1'b0;
         evt_ch     <= '0;
         pending    <= '0;
         last_grant <= CH_W'(N_CH - 1);
         drop_cnt   <= '0;
         drop_flag  <= 1'b0;
      end else begin
         pending   <= pend_next;
         drop_cnt  <= cnt_next;
         drop_flag <= (drop_flag & ~clr_drop) | (|lost);
         case (state)
            IDLE: begin
               if (en && pick.found) begin
                  evt_ch    <= pick_idx;
                  evt_valid <= 1'b1;
                  state     <= OFFER;
               end
            end
            OFFER: begin
               if (evt_ready) begin
                  last_grant <= evt_ch;
                  if (en && pick.found) begin
                     evt_ch <= pick_idx;
                  end else begin
                     evt_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
